// File: rtl/ttt_pkg.sv
// Shared types and constants for the ttt token pipeline.
// token_event_t is sized for the default core (15 processors, 8-bit ticks).
package ttt_pkg;

  typedef enum logic [1:0] {
    STAGE_WAIT     = 2'b00,
    STAGE_UPDATE   = 2'b01,
    STAGE_CHECK    = 2'b10,
    STAGE_TRANSMIT = 2'b11
  } stage_t;

  localparam logic [1:0] SS_NONE  = 2'b00;
  localparam logic [1:0] SS_START = 2'b01;
  localparam logic [1:0] SS_STOP  = 2'b10;
  localparam logic [1:0] SS_BOTH  = 2'b11;

  localparam int TTT_ID_W   = 4;
  localparam int TTT_TICK_W = 8;

  typedef struct packed {
    logic [TTT_ID_W-1:0]   processor_id;
    logic [1:0]            startstop;
    logic [TTT_TICK_W-1:0] tick;
  } token_event_t;

endpackage

// File: rtl/ttt_sync_fifo.sv
// Generic first-word-fall-through FIFO. A push into a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module ttt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock_fast,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count gates visibility of stale entries.
  always_ff @(posedge clock_fast) begin
    if (!reset && !clear && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ttt_event_buffer.sv
// Timestamps non-empty token events from the main core with a step counter
// and queues them for the host to drain at its own pace.
module ttt_event_buffer
  import ttt_pkg::*;
#(
  parameter int NUM_PROCESSORS = 15,
  parameter int DEPTH          = 8,
  parameter int TICK_BITS      = 8,
  localparam int ID_W = $clog2(NUM_PROCESSORS),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                 clock_fast,
  input  logic                 reset,
  input  logic [1:0]           stage,
  input  logic                 output_valid,
  input  logic [ID_W-1:0]      processor_id_in,
  input  logic [1:0]           token_startstop_in,
  input  logic                 pop,
  input  logic                 clear,
  output logic                 event_valid,
  output logic [ID_W-1:0]      event_processor_id,
  output logic [1:0]           event_startstop,
  output logic [TICK_BITS-1:0] event_tick,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 overflow
);

  typedef struct packed {
    logic [ID_W-1:0]      processor_id;
    logic [1:0]           startstop;
    logic [TICK_BITS-1:0] tick;
  } ev_t;

  stage_t               prev_stage_q, prev_stage_d;
  logic [TICK_BITS-1:0] tick_q, tick_d;
  logic                 overflow_q, overflow_d;
  logic                 push_req, fifo_empty, fifo_full;
  ev_t                  push_ev, head_ev;

  always_comb begin
    prev_stage_d = stage_t'(stage);
    tick_d       = tick_q;
    // A step completes when transmit hands back to wait.
    if (prev_stage_q == STAGE_TRANSMIT && stage_t'(stage) == STAGE_WAIT)
      tick_d = tick_q + TICK_BITS'(1);

    push_req = output_valid && (token_startstop_in != SS_NONE);
    push_ev  = '{processor_id: processor_id_in,
                 startstop:    token_startstop_in,
                 tick:         tick_q};

    overflow_d = overflow_q;
    if (clear)                               overflow_d = 1'b0;
    else if (push_req && fifo_full && !pop)  overflow_d = 1'b1;
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      prev_stage_q <= STAGE_WAIT;
      tick_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_stage_q <= prev_stage_d;
      tick_q       <= tick_d;
      overflow_q   <= overflow_d;
    end
  end

  ttt_sync_fifo #(
    .WIDTH ($bits(ev_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_fast (clock_fast),
    .reset      (reset),
    .clear      (clear),
    .push       (push_req),
    .push_data  (push_ev),
    .pop        (pop),
    .head_data  (head_ev),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (count)
  );

  assign event_valid        = !fifo_empty;
  assign event_processor_id = head_ev.processor_id;
  assign event_startstop    = head_ev.startstop;
  assign event_tick         = head_ev.tick;
  assign full               = fifo_full;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_ttt_event_buffer.sv
// Directed bench for ttt_event_buffer with hand-computed expectations.
module tb_ttt_event_buffer;

  logic       clock_fast = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] stage = 2'b00;
  logic       output_valid = 1'b0;
  logic [3:0] processor_id_in = '0;
  logic [1:0] token_startstop_in = '0;
  logic       pop = 1'b0;
  logic       clear = 1'b0;
  logic       event_valid;
  logic [3:0] event_processor_id;
  logic [1:0] event_startstop;
  logic [7:0] event_tick;
  logic [3:0] count;
  logic       full;
  logic       overflow;

  int n_asserts = 0;
  int n_fails   = 0;

  ttt_event_buffer dut (
    .clock_fast         (clock_fast),
    .reset              (reset),
    .stage              (stage),
    .output_valid       (output_valid),
    .processor_id_in    (processor_id_in),
    .token_startstop_in (token_startstop_in),
    .pop                (pop),
    .clear              (clear),
    .event_valid        (event_valid),
    .event_processor_id (event_processor_id),
    .event_startstop    (event_startstop),
    .event_tick         (event_tick),
    .count              (count),
    .full               (full),
    .overflow           (overflow)
  );

  always #5 clock_fast = ~clock_fast;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock_fast);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [3:0] id, input logic [1:0] ss);
    output_valid = 1'b1; processor_id_in = id; token_startstop_in = ss;
    step();
    output_valid = 1'b0; token_startstop_in = 2'b00;
  endtask

  task automatic do_pop();
    pop = 1'b1; step(); pop = 1'b0;
  endtask

  // One full wait->update->check->transmit->wait pass; tick bumps on the final edge.
  task automatic run_step();
    stage = 2'b01; step();
    stage = 2'b10; step();
    stage = 2'b11; step();
    stage = 2'b00; step();
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk("rst_valid", 32'(event_valid), 0);
    chk("rst_id",    32'(event_processor_id), 0);
    chk("rst_ss",    32'(event_startstop), 0);
    chk("rst_tick",  32'(event_tick), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_ovf",   32'(overflow), 0);

    // Single event
    push_ev(4'd3, 2'b01);
    chk("single_valid", 32'(event_valid), 1);
    chk("single_id",    32'(event_processor_id), 3);
    chk("single_ss",    32'(event_startstop), 1);
    chk("single_tick",  32'(event_tick), 0);
    chk("single_count", 32'(count), 1);
    do_pop();
    chk("single_popped", 32'(event_valid), 0);
    do_pop();
    chk("underflow_count", 32'(count), 0);
    chk("underflow_valid", 32'(event_valid), 0);

    // Tick stamping: event in first wait cycle after third transmit carries 2
    run_step();
    run_step();
    stage = 2'b01; step();
    stage = 2'b10; step();
    stage = 2'b11; step();
    stage = 2'b00;
    push_ev(4'd7, 2'b11);
    chk("stamp_id",   32'(event_processor_id), 7);
    chk("stamp_ss",   32'(event_startstop), 3);
    chk("stamp_tick", 32'(event_tick), 2);
    push_ev(4'd5, 2'b01);
    do_pop();
    chk("stamp_next_id",   32'(event_processor_id), 5);
    chk("stamp_next_tick", 32'(event_tick), 3);
    do_pop();
    chk("stamp_empty", 32'(count), 0);

    // Fill and overflow, with code-00 pulses interleaved
    for (int i = 0; i < 9; i++) begin
      push_ev(4'(i), (i % 2 == 1) ? 2'b10 : 2'b01);
      push_ev(4'hf, 2'b00);
    end
    chk("fill_full",  32'(full), 1);
    chk("fill_count", 32'(count), 8);
    chk("fill_ovf",   32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(event_valid), 1);
      chk("drain_id",    32'(event_processor_id), 32'(i));
      chk("drain_ss",    32'(event_startstop), (i % 2 == 1) ? 2 : 1);
      chk("drain_tick",  32'(event_tick), 3);
      do_pop();
    end
    chk("drain_empty", 32'(event_valid), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_ovf", 32'(overflow), 0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_ev(4'(i), 2'b01);
    chk("pp_pre_count", 32'(count), 8);
    pop = 1'b1;
    push_ev(4'd9, 2'b10);
    pop = 1'b0;
    chk("pp_count", 32'(count), 8);
    chk("pp_full",  32'(full), 1);
    chk("pp_ovf",   32'(overflow), 0);
    chk("pp_head",  32'(event_processor_id), 1);
    for (int i = 1; i < 8; i++) begin
      chk("pp_drain_id", 32'(event_processor_id), 32'(i));
      do_pop();
    end
    chk("pp_last_id", 32'(event_processor_id), 9);
    chk("pp_last_ss", 32'(event_startstop), 2);
    do_pop();
    chk("pp_empty", 32'(event_valid), 0);

    // Clear and reset
    run_step();
    for (int i = 0; i < 9; i++) push_ev(4'(i), 2'b01);
    do_pop(); do_pop(); do_pop();
    chk("cl_pre_count", 32'(count), 5);
    chk("cl_pre_ovf",   32'(overflow), 1);
    clear = 1'b1;
    push_ev(4'd12, 2'b01);
    clear = 1'b0;
    chk("cl_count", 32'(count), 0);
    chk("cl_ovf",   32'(overflow), 0);
    chk("cl_valid", 32'(event_valid), 0);
    push_ev(4'd2, 2'b01);
    chk("cl_tick_kept", 32'(event_tick), 4);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst2_count", 32'(count), 0);
    chk("rst2_valid", 32'(event_valid), 0);
    push_ev(4'd1, 2'b10);
    chk("rst2_tick", 32'(event_tick), 0);
    do_pop();

    // Tick wrap: after 255 steps tick is 255; event in the wrap cycle carries 255
    for (int i = 0; i < 255; i++) run_step();
    stage = 2'b01; step();
    stage = 2'b10; step();
    stage = 2'b11; step();
    stage = 2'b00;
    push_ev(4'd4, 2'b01);
    chk("wrap_tick", 32'(event_tick), 255);
    push_ev(4'd6, 2'b10);
    do_pop();
    chk("wrap_after_id",   32'(event_processor_id), 6);
    chk("wrap_after_tick", 32'(event_tick), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
